elevator_request_tracker: RTL and testbench

//  Clocked, N-floor successor of the 4-floor latch-based request store and call-summary logic.

---
 rtl/elevator_pkg.sv | 23 ++
 rtl/floor_req_summary.sv | 37 +++
 rtl/elevator_request_tracker.sv | 136 +++++++++++++
 tb/tb_elevator_request_tracker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared constants and helpers for the elevator request tracker.
// The optional press-to-cancel feature is enabled with ELEV_REQ_CANCEL_EN.
package elevator_pkg;

    localparam int DEFAULT_NUM_FLOORS = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int CTRL_HERE  = 0;
    localparam int CTRL_ABOVE = 1;
    localparam int CTRL_BELOW = 2;

    // Position width, never narrower than one bit.
    function automatic int floor_pos_w(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/floor_req_summary.sv
// Reduces a request vector to {below, above, here} relative to the cabin floor.
// Bit i of req belongs to floor i + OFFSET.
module floor_req_summary
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
    parameter int OFFSET     = 0,
    parameter int REQ_W      = NUM_FLOORS - OFFSET,
    parameter int POS_W      = floor_pos_w(NUM_FLOORS)
) (
    input  logic [REQ_W-1:0] req,
    input  logic [POS_W-1:0] pos,
    output logic [2:0]       summary
);

    logic [31:0] pos_ext_s;

    // Classify every pending bit as here, above or below the cabin.
    always_comb begin
        summary   = 3'b000;
        pos_ext_s = 32'(pos);
        for (int i = 0; i < REQ_W; i++) begin
            if (req[i]) begin
                if (32'(i + OFFSET) == pos_ext_s) begin
                    summary[CTRL_HERE] = 1'b1;
                end else if (32'(i + OFFSET) > pos_ext_s) begin
                    summary[CTRL_ABOVE] = 1'b1;
                end else begin
                    summary[CTRL_BELOW] = 1'b1;
                end
            end else begin
                summary = summary;
            end
        end
    end

endmodule

// File: rtl/elevator_request_tracker.sv
// Sticky cabin/hall request store with door-open clearing and position summaries.
// Define ELEV_REQ_CANCEL_EN to let a fresh press on a lit cabin button cancel it.
module elevator_request_tracker
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
    parameter int POS_W      = floor_pos_w(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] button_in,
    input  logic [NUM_FLOORS-2:0] button_up,
    input  logic [NUM_FLOORS-2:0] button_down,
    input  logic [POS_W-1:0]      pos,
    input  logic                  open,
    input  logic                  dir_up,
    output logic [NUM_FLOORS-1:0] req_in,
    output logic [NUM_FLOORS-2:0] req_up,
    output logic [NUM_FLOORS-2:0] req_down,
    output logic [2:0]            ctrl_in,
    output logic [2:0]            ctrl_up,
    output logic [2:0]            ctrl_down,
    output logic [POS_W:0]        pending_cnt,
    output logic                  any_pending
);

    logic [NUM_FLOORS-1:0] req_in_r;
    logic [NUM_FLOORS-2:0] req_up_r;
    logic [NUM_FLOORS-2:0] req_down_r;
    logic [NUM_FLOORS-1:0] clear_in_s;
    logic [NUM_FLOORS-2:0] clear_up_s;
    logic [NUM_FLOORS-2:0] clear_down_s;
    logic [NUM_FLOORS-1:0] set_in_s;
    logic [NUM_FLOORS-1:0] cancel_s;
    logic [2:0]            sum_in_s;
    logic [2:0]            sum_up_s;
    logic [2:0]            sum_down_s;
    logic                  any_above_s;
    logic                  any_below_s;
    logic [31:0]           pos_ext_s;
    logic [POS_W:0]        cnt_s;

    floor_req_summary #(.NUM_FLOORS(NUM_FLOORS), .OFFSET(0), .REQ_W(NUM_FLOORS), .POS_W(POS_W))
        u_sum_in (.req(req_in_r), .pos(pos), .summary(sum_in_s));
    floor_req_summary #(.NUM_FLOORS(NUM_FLOORS), .OFFSET(0), .REQ_W(NUM_FLOORS-1), .POS_W(POS_W))
        u_sum_up (.req(req_up_r), .pos(pos), .summary(sum_up_s));
    floor_req_summary #(.NUM_FLOORS(NUM_FLOORS), .OFFSET(1), .REQ_W(NUM_FLOORS-1), .POS_W(POS_W))
        u_sum_down (.req(req_down_r), .pos(pos), .summary(sum_down_s));

    assign any_above_s = sum_in_s[CTRL_ABOVE] | sum_up_s[CTRL_ABOVE] | sum_down_s[CTRL_ABOVE];
    assign any_below_s = sum_in_s[CTRL_BELOW] | sum_up_s[CTRL_BELOW] | sum_down_s[CTRL_BELOW];

`ifdef ELEV_REQ_CANCEL_EN
    logic [NUM_FLOORS-1:0] btn_prev_r;
    logic [NUM_FLOORS-1:0] rise_s;

    // Previous cabin button level for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_prev_r <= {NUM_FLOORS{1'b0}};
        end else begin
            btn_prev_r <= button_in;
        end
    end

    // Only fresh presses act: unlit buttons light, lit ones cancel.
    assign rise_s   = button_in & ~btn_prev_r;
    assign set_in_s = rise_s & ~req_in_r;
    assign cancel_s = rise_s & req_in_r;
`else
    assign set_in_s = button_in;
    assign cancel_s = {NUM_FLOORS{1'b0}};
`endif

    // Serve the floor at pos; an out-of-range pos matches no floor and clears nothing.
    always_comb begin
        clear_in_s   = {NUM_FLOORS{1'b0}};
        clear_up_s   = {(NUM_FLOORS-1){1'b0}};
        clear_down_s = {(NUM_FLOORS-1){1'b0}};
        pos_ext_s    = 32'(pos);
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (open && (pos_ext_s == 32'(f))) begin
                clear_in_s[f] = 1'b1;
            end else begin
                clear_in_s[f] = 1'b0;
            end
        end
        for (int f = 0; f < NUM_FLOORS - 1; f++) begin
            if (open && (pos_ext_s == 32'(f)) && ((dir_up == DIR_UP) || !any_below_s)) begin
                clear_up_s[f] = 1'b1;
            end else begin
                clear_up_s[f] = 1'b0;
            end
            if (open && (pos_ext_s == 32'(f + 1)) && ((dir_up == DIR_DOWN) || !any_above_s)) begin
                clear_down_s[f] = 1'b1;
            end else begin
                clear_down_s[f] = 1'b0;
            end
        end
    end

    // Sticky request flops; a clear in the same cycle beats a set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_in_r   <= {NUM_FLOORS{1'b0}};
            req_up_r   <= {(NUM_FLOORS-1){1'b0}};
            req_down_r <= {(NUM_FLOORS-1){1'b0}};
        end else begin
            req_in_r   <= ((req_in_r & ~cancel_s) | set_in_s) & ~clear_in_s;
            req_up_r   <= (req_up_r | button_up) & ~clear_up_s;
            req_down_r <= (req_down_r | button_down) & ~clear_down_s;
        end
    end

    // Population count of pending cabin requests.
    always_comb begin
        cnt_s = {(POS_W+1){1'b0}};
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (req_in_r[f]) begin
                cnt_s = cnt_s + {{POS_W{1'b0}}, 1'b1};
            end else begin
                cnt_s = cnt_s;
            end
        end
    end

    assign req_in      = req_in_r;
    assign req_up      = req_up_r;
    assign req_down    = req_down_r;
    assign ctrl_in     = sum_in_s;
    assign ctrl_up     = sum_up_s;
    assign ctrl_down   = sum_down_s;
    assign pending_cnt = cnt_s;
    assign any_pending = (|req_in_r) | (|req_up_r) | (|req_down_r);

endmodule

// File: tb/tb_elevator_request_tracker.sv
// Directed bench for elevator_request_tracker: a 4-floor and a 6-floor instance.
module tb_elevator_request_tracker;

    logic       clk;
    logic       reset_n;

    logic [3:0] button_in;
    logic [2:0] button_up;
    logic [2:0] button_down;
    logic [1:0] pos;
    logic       open;
    logic       dir_up;
    logic [3:0] req_in;
    logic [2:0] req_up;
    logic [2:0] req_down;
    logic [2:0] ctrl_in;
    logic [2:0] ctrl_up;
    logic [2:0] ctrl_down;
    logic [2:0] pending_cnt;
    logic       any_pending;

    logic [5:0] b6_in;
    logic [4:0] b6_up;
    logic [4:0] b6_down;
    logic [2:0] pos6;
    logic       open6;
    logic       dir6;
    logic [5:0] req_in6;
    logic [4:0] req_up6;
    logic [4:0] req_down6;
    logic [2:0] ctrl_in6;
    logic [2:0] ctrl_up6;
    logic [2:0] ctrl_down6;
    logic [3:0] pending_cnt6;
    logic       any_pending6;

    int checks = 0;
    int errors = 0;

    elevator_request_tracker #(.NUM_FLOORS(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .button_in(button_in), .button_up(button_up), .button_down(button_down),
        .pos(pos), .open(open), .dir_up(dir_up),
        .req_in(req_in), .req_up(req_up), .req_down(req_down),
        .ctrl_in(ctrl_in), .ctrl_up(ctrl_up), .ctrl_down(ctrl_down),
        .pending_cnt(pending_cnt), .any_pending(any_pending)
    );

    elevator_request_tracker #(.NUM_FLOORS(6)) dut6 (
        .clk(clk), .reset_n(reset_n),
        .button_in(b6_in), .button_up(b6_up), .button_down(b6_down),
        .pos(pos6), .open(open6), .dir_up(dir6),
        .req_in(req_in6), .req_up(req_up6), .req_down(req_down6),
        .ctrl_in(ctrl_in6), .ctrl_up(ctrl_up6), .ctrl_down(ctrl_down6),
        .pending_cnt(pending_cnt6), .any_pending(any_pending6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        button_in = 4'b0000; button_up = 3'b000; button_down = 3'b000;
        pos = 2'd0; open = 1'b0; dir_up = 1'b1;
        b6_in = 6'b000000; b6_up = 5'b00000; b6_down = 5'b00000;
        pos6 = 3'd0; open6 = 1'b0; dir6 = 1'b1;
        #2;
        check("reset_req_in", 32'(req_in), 32'h0);
        check("reset_ctrl_in", 32'(ctrl_in), 32'h0);
        check("reset_pending", 32'(pending_cnt), 32'h0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Latch a single cabin request at floor 3 and watch it hold
        button_in = 4'b1000;
        step();
        button_in = 4'b0000;
        check("latch_req_in", 32'(req_in), 32'h8);
        check("latch_ctrl_in", 32'(ctrl_in), 32'h2);
        check("latch_pending", 32'(pending_cnt), 32'h1);
        check("latch_any", 32'(any_pending), 32'h1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_req_in", 32'(req_in), 32'h8);
            check("hold_ctrl_in", 32'(ctrl_in), 32'h2);
        end

        // Asynchronous reset mid-run with req_in = 1011
        button_in = 4'b0011;
        step();
        button_in = 4'b0000;
        check("pre_reset_req_in", 32'(req_in), 32'hB);
        check("pre_reset_pending", 32'(pending_cnt), 32'h3);
        check("pre_reset_ctrl_in", 32'(ctrl_in), 32'h3);
        #2;
        reset_n = 1'b0;
        #2;
        check("async_reset_req_in", 32'(req_in), 32'h0);
        check("async_reset_pending", 32'(pending_cnt), 32'h0);
        check("async_reset_ctrl_in", 32'(ctrl_in), 32'h0);
        check("async_reset_any", 32'(any_pending), 32'h0);
        step();
        reset_n = 1'b1;
        step();
        check("post_reset_req_in", 32'(req_in), 32'h0);
        check("post_reset_any", 32'(any_pending), 32'h0);

        // Serve going up at floor 2 while floor 3 still pending
        button_up = 3'b100; button_down = 3'b010; button_in = 4'b1000;
        step();
        button_up = 3'b000; button_down = 3'b000; button_in = 4'b0000;
        check("setup_req_up", 32'(req_up), 32'h4);
        check("setup_req_down", 32'(req_down), 32'h2);
        check("setup_ctrl_up", 32'(ctrl_up), 32'h2);
        check("setup_ctrl_down", 32'(ctrl_down), 32'h2);
        pos = 2'd2; open = 1'b1; dir_up = 1'b1;
        #1;
        check("at2_ctrl_up", 32'(ctrl_up), 32'h1);
        check("at2_ctrl_down", 32'(ctrl_down), 32'h1);
        check("at2_ctrl_in", 32'(ctrl_in), 32'h2);
        step();
        check("serve_up_req_up", 32'(req_up), 32'h0);
        check("serve_up_keep_down", 32'(req_down), 32'h2);
        check("serve_up_req_in", 32'(req_in), 32'h8);
        pos = 2'd3;
        step();
        check("serve3_req_in", 32'(req_in), 32'h0);
        check("serve3_keep_down", 32'(req_down), 32'h2);
        pos = 2'd2;
        step();
        check("serve_top_down", 32'(req_down), 32'h0);
        check("serve_top_any", 32'(any_pending), 32'h0);

        // Press at the open floor is not stored
        pos = 2'd1; open = 1'b1; button_in = 4'b0010;
        step();
        button_in = 4'b0000;
        check("collision_req_in", 32'(req_in), 32'h0);
        open = 1'b0;

        // Serve going down at floor 1 with floor 0 pending
        pos = 2'd3; button_up = 3'b010; button_down = 3'b001; button_in = 4'b0001;
        step();
        button_up = 3'b000; button_down = 3'b000; button_in = 4'b0000;
        pos = 2'd1; open = 1'b1; dir_up = 1'b0;
        step();
        check("dn_clear_down", 32'(req_down), 32'h0);
        check("dn_keep_up", 32'(req_up), 32'h2);
        check("dn_ctrl_in", 32'(ctrl_in), 32'h4);
        pos = 2'd0;
        step();
        check("dn_serve0_in", 32'(req_in), 32'h0);
        pos = 2'd1;
        step();
        check("dn_clear_up", 32'(req_up), 32'h0);
        open = 1'b0;

        // All cabin buttons: count reaches NUM_FLOORS
        button_in = 4'b1111;
        step();
        button_in = 4'b0000;
        check("full_pending", 32'(pending_cnt), 32'h4);
        check("full_any", 32'(any_pending), 32'h1);
        #2;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        // Illegal position on the 6-floor instance
        pos6 = 3'd7;
        b6_in = 6'b100101; b6_up = 5'b00010; b6_down = 5'b10000;
        step();
        b6_in = 6'b000000; b6_up = 5'b00000; b6_down = 5'b00000;
        check("p6_setup_in", 32'(req_in6), 32'h25);
        open6 = 1'b1; dir6 = 1'b1;
        #1;
        check("p6_ctrl_in", 32'(ctrl_in6), 32'h4);
        check("p6_ctrl_up", 32'(ctrl_up6), 32'h4);
        step();
        check("p6_up_req_in", 32'(req_in6), 32'h25);
        check("p6_up_req_up", 32'(req_up6), 32'h2);
        check("p6_up_req_down", 32'(req_down6), 32'h10);
        dir6 = 1'b0;
        step();
        check("p6_dn_req_in", 32'(req_in6), 32'h25);
        check("p6_dn_req_down", 32'(req_down6), 32'h10);
        check("p6_pending", 32'(pending_cnt6), 32'h3);
        open6 = 1'b0; pos6 = 3'd5;
        #1;
        check("p6_top_ctrl_in", 32'(ctrl_in6), 32'h5);

        // Pressing a lit cabin button
        pos = 2'd0; open = 1'b0;
        button_in = 4'b0100;
        step();
        button_in = 4'b0000;
        step();
        check("cancel_setup", 32'(req_in), 32'h4);
        button_in = 4'b0100;
        step();
`ifdef ELEV_REQ_CANCEL_EN
        check("cancel_press", 32'(req_in), 32'h0);
        step();
        check("cancel_hold", 32'(req_in), 32'h0);
        button_in = 4'b0000;
        step();
        check("cancel_release", 32'(req_in), 32'h0);
`else
        check("cancel_press", 32'(req_in), 32'h4);
        step();
        check("cancel_hold", 32'(req_in), 32'h4);
        button_in = 4'b0000;
        step();
        check("cancel_release", 32'(req_in), 32'h4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
